constraint_sample_gen: RTL and testbench

Rejection-sampling stimulus generator that drives candidate values into a generated constraint-checker module and returns only the candidates the checker accepts. It is the producer side of the checker interface. It emits five operand fields sized to match the checker's inputs, then samples the checker's single combinational satisfaction bit. Accepted samples leave through a valid/ready stream toward the bench or the result collector.

---
 rtl/sampler_pkg.sv | 25 ++
 rtl/sampler_lfsr64.sv | 27 ++
 rtl/constraint_sample_gen.sv | 149 ++++++++++++++
 tb/tb_constraint_sample_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_pkg.sv
// Shared types and constants for the rejection-sampling stimulus generator.
package sampler_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGen,
        StCheck,
        StHold
    } sampler_state_t;

    localparam logic [63:0] LFSR_POLY      = 64'hD800_0000_0000_0000;
    localparam logic [63:0] LFSR_ZERO_SEED = 64'h1;

    localparam int unsigned DEF_VAR0_W = 13;
    localparam int unsigned DEF_VAR1_W = 13;
    localparam int unsigned DEF_VAR2_W = 14;
    localparam int unsigned DEF_VAR3_W = 14;
    localparam int unsigned DEF_VAR4_W = 8;

    // One right-shifting Galois step for x^64+x^63+x^61+x^60+1.
    function automatic logic [63:0] lfsr_next(input logic [63:0] state);
        return (state >> 1) ^ (state[0] ? LFSR_POLY : 64'h0);
    endfunction

endpackage

// File: rtl/sampler_lfsr64.sv
// 64-bit Galois LFSR with seed load; an all-zero seed is replaced so the state never locks up.
module sampler_lfsr64
    import sampler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [63:0] i_seed,
    input  logic        i_step,
    output logic [63:0] o_state
);

    logic [63:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LFSR_ZERO_SEED;
        end else if (i_load) begin
            r_state <= (i_seed == 64'h0) ? LFSR_ZERO_SEED : i_seed;
        end else if (i_step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/constraint_sample_gen.sv
// Rejection-sampling producer for a constraint checker; optional counters under SAMPLER_STATS_EN.
module constraint_sample_gen
    import sampler_pkg::*;
#(
    parameter int unsigned VAR0_W    = DEF_VAR0_W,
    parameter int unsigned VAR1_W    = DEF_VAR1_W,
    parameter int unsigned VAR2_W    = DEF_VAR2_W,
    parameter int unsigned VAR3_W    = DEF_VAR3_W,
    parameter int unsigned VAR4_W    = DEF_VAR4_W,
    parameter int unsigned MAX_TRIES = 1024,
    parameter int unsigned TRY_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [63:0]       seed,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [VAR0_W-1:0] cand_var_0,
    output logic [VAR1_W-1:0] cand_var_1,
    output logic [VAR2_W-1:0] cand_var_2,
    output logic [VAR3_W-1:0] cand_var_3,
    output logic [VAR4_W-1:0] cand_var_4,
    input  logic              cand_sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VAR0_W-1:0] out_var_0,
    output logic [VAR1_W-1:0] out_var_1,
    output logic [VAR2_W-1:0] out_var_2,
    output logic [VAR3_W-1:0] out_var_3,
    output logic [VAR4_W-1:0] out_var_4,
    output logic [TRY_W-1:0]  out_tries,
    output logic              out_fail
`ifdef SAMPLER_STATS_EN
    ,
    output logic [31:0]       stat_accept,
    output logic [31:0]       stat_reject
`endif
);

    localparam int unsigned OFF1    = VAR0_W;
    localparam int unsigned OFF2    = OFF1 + VAR1_W;
    localparam int unsigned OFF3    = OFF2 + VAR2_W;
    localparam int unsigned OFF4    = OFF3 + VAR3_W;
    localparam int unsigned TOTAL_W = OFF4 + VAR4_W;

    sampler_state_t r_state;
    logic [TRY_W-1:0] r_tries;
    logic [63:0] w_lfsr_state;
    logic [63:0] w_lfsr_next;
    logic w_last_try;

    // Candidates are taken from the post-step value so they match the LFSR after GEN.
    assign w_lfsr_next = lfsr_next(w_lfsr_state);
    assign w_last_try  = (r_tries == TRY_W'(MAX_TRIES));

    sampler_lfsr64 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (seed_load && (r_state == StIdle)),
        .i_seed  (seed),
        .i_step  (r_state == StGen),
        .o_state (w_lfsr_state)
    );

    if (TOTAL_W < 64) begin : g_unused_bits
        logic w_unused_lfsr;
        assign w_unused_lfsr = ^w_lfsr_next[63:TOTAL_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_tries    <= '0;
            req_ready  <= 1'b1;
            out_valid  <= 1'b0;
            out_fail   <= 1'b0;
            out_tries  <= '0;
            cand_var_0 <= '0;
            cand_var_1 <= '0;
            cand_var_2 <= '0;
            cand_var_3 <= '0;
            cand_var_4 <= '0;
            out_var_0  <= '0;
            out_var_1  <= '0;
            out_var_2  <= '0;
            out_var_3  <= '0;
            out_var_4  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_tries   <= '0;
                        req_ready <= 1'b0;
                        r_state   <= StGen;
                    end
                end
                StGen: begin
                    cand_var_0 <= w_lfsr_next[0 +: VAR0_W];
                    cand_var_1 <= w_lfsr_next[OFF1 +: VAR1_W];
                    cand_var_2 <= w_lfsr_next[OFF2 +: VAR2_W];
                    cand_var_3 <= w_lfsr_next[OFF3 +: VAR3_W];
                    cand_var_4 <= w_lfsr_next[OFF4 +: VAR4_W];
                    r_tries    <= r_tries + TRY_W'(1);
                    r_state    <= StCheck;
                end
                StCheck: begin
                    if (cand_sat || w_last_try) begin
                        out_var_0 <= cand_var_0;
                        out_var_1 <= cand_var_1;
                        out_var_2 <= cand_var_2;
                        out_var_3 <= cand_var_3;
                        out_var_4 <= cand_var_4;
                        out_tries <= r_tries;
                        out_fail  <= ~cand_sat;
                        out_valid <= 1'b1;
                        r_state   <= StHold;
                    end else begin
                        r_state <= StGen;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef SAMPLER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_accept <= '0;
            stat_reject <= '0;
        end else if (r_state == StCheck) begin
            if (cand_sat) begin
                if (stat_accept != 32'hFFFF_FFFF) stat_accept <= stat_accept + 32'd1;
            end else begin
                if (stat_reject != 32'hFFFF_FFFF) stat_reject <= stat_reject + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_constraint_sample_gen.sv
// Randomized self-checking bench for constraint_sample_gen against a behavioural sampling model.
module tb_constraint_sample_gen;

    localparam int unsigned MAX_TRIES = 4;
    localparam int unsigned TRY_W     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [63:0] seed = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [12:0] cand_var_0, cand_var_1, out_var_0, out_var_1;
    logic [13:0] cand_var_2, cand_var_3, out_var_2, out_var_3;
    logic [7:0]  cand_var_4, out_var_4;
    logic        cand_sat;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [TRY_W-1:0] out_tries;
    logic        out_fail;
`ifdef SAMPLER_STATS_EN
    logic [31:0] stat_accept, stat_reject;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_acc = 0;
    int          exp_rej = 0;
    logic [63:0] m_lfsr = 64'h1;
    int          sat_mode = 0;
    logic [61:0] target = '0;

    always #5 clk = ~clk;

    constraint_sample_gen #(
        .MAX_TRIES (MAX_TRIES),
        .TRY_W     (TRY_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed       (seed),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .cand_var_0 (cand_var_0),
        .cand_var_1 (cand_var_1),
        .cand_var_2 (cand_var_2),
        .cand_var_3 (cand_var_3),
        .cand_var_4 (cand_var_4),
        .cand_sat   (cand_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_var_0  (out_var_0),
        .out_var_1  (out_var_1),
        .out_var_2  (out_var_2),
        .out_var_3  (out_var_3),
        .out_var_4  (out_var_4),
        .out_tries  (out_tries),
        .out_fail   (out_fail)
`ifdef SAMPLER_STATS_EN
        ,
        .stat_accept (stat_accept),
        .stat_reject (stat_reject)
`endif
    );

    // Stand-in checker: combinational predicate over the candidate fields.
    always_comb begin
        cand_sat = 1'b0;
        case (sat_mode)
            1: cand_sat = 1'b1;
            2: cand_sat = ((cand_var_0[1:0] ^ cand_var_4[1:0]) == 2'b00);
            3: cand_sat = cand_var_1[0];
            4: cand_sat = ({cand_var_4, cand_var_3, cand_var_2, cand_var_1, cand_var_0} == target);
            default: cand_sat = 1'b0;
        endcase
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Galois LFSR as polynomial arithmetic: divide by x, folding the x^0 term back via the taps.
    function automatic logic [63:0] m_step(input logic [63:0] s);
        logic [63:0] r;
        r = s / 2;
        if ((s % 2) == 1) r = r ^ 64'hD800_0000_0000_0000;
        return r;
    endfunction

    function automatic bit m_pred(input int mode, input logic [63:0] s);
        logic [12:0] f0;
        logic [12:0] f1;
        logic [7:0]  f4;
        f0 = 13'(s);
        f1 = 13'(s >> 13);
        f4 = 8'(s >> 54);
        case (mode)
            1: return 1'b1;
            2: return ((f0 ^ 13'(f4)) % 4) == 0;
            3: return (f1 % 2) == 1;
            4: return (s % (64'h1 << 62)) == 64'(target);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_req(input int mode, input bit ld, input logic [63:0] sd, input int hold);
        logic [63:0] s;
        int k;
        bit sat;
        int n;
        check_val("idle_req_ready", 64'(req_ready), 64'd1);
        if (ld) begin
            seed_load = 1'b1;
            seed = sd;
            m_lfsr = (sd == 64'h0) ? 64'h1 : sd;
        end
        sat_mode = mode;
        req_valid = 1'b1;
        s = m_lfsr;
        k = 0;
        sat = 1'b0;
        do begin
            s = m_step(s);
            k++;
            sat = m_pred(mode, s);
        end while (!sat && k < int'(MAX_TRIES));
        m_lfsr = s;
        exp_rej += k - (sat ? 1 : 0);
        exp_acc += sat ? 1 : 0;
        @(posedge clk); #1;
        seed_load = 1'b0;
        req_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 2 * int'(MAX_TRIES) + 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            check_val("out_valid_timeout", 64'(out_valid), 64'd1);
            return;
        end
        check_val("latency", 64'(n), 64'(1 + 2 * k));
        check_val("out_tries", 64'(out_tries), 64'(k));
        check_val("out_fail", 64'(out_fail), 64'(!sat));
        check_val("out_var_0", 64'(out_var_0), 64'(13'(s)));
        check_val("out_var_1", 64'(out_var_1), 64'(13'(s >> 13)));
        check_val("out_var_2", 64'(out_var_2), 64'(14'(s >> 26)));
        check_val("out_var_3", 64'(out_var_3), 64'(14'(s >> 40)));
        check_val("out_var_4", 64'(out_var_4), 64'(8'(s >> 54)));
        check_val("hold_req_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("bp_valid", 64'(out_valid), 64'd1);
            check_val("bp_req_ready", 64'(req_ready), 64'd0);
            check_val("bp_var_2", 64'(out_var_2), 64'(14'(s >> 26)));
            check_val("bp_tries", 64'(out_tries), 64'(k));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("post_hs_valid", 64'(out_valid), 64'd0);
        check_val("post_hs_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] s;
        int seen;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_req_ready", 64'(req_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_fail", 64'(out_fail), 64'd0);
        check_val("rst_out_tries", 64'(out_tries), 64'd0);
        check_val("rst_cand_var_4", 64'(cand_var_4), 64'd0);
        check_val("rst_out_var_0", 64'(out_var_0), 64'd0);

        run_req(1, 1'b1, 64'h1, 0);
        run_req(0, 1'b0, 64'h0, 0);
        s = m_step(m_step(m_step(m_lfsr)));
        target = s[61:0];
        run_req(4, 1'b0, 64'h0, 0);
        run_req(1, 1'b0, 64'h0, 5);

        // Reset pulsed during the second CHECK of a request that would otherwise fail.
        sat_mode = 0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrst_req_ready", 64'(req_ready), 64'd1);
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        check_val("midrst_cand_var_0", 64'(cand_var_0), 64'd0);
        seen = 0;
        out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        check_val("midrst_no_output", 64'(seen), 64'd0);
        m_lfsr = 64'h1;
        exp_acc = 0;
        exp_rej = 0;
        run_req(1, 1'b0, 64'h0, 0);

        for (int p = 0; p < 2; p++) begin
            run_req(2, 1'b1, 64'hDEAD_BEEF_0123_4567, 0);
            run_req(3, 1'b0, 64'h0, 1);
            run_req(2, 1'b0, 64'h0, 0);
        end
        run_req(1, 1'b1, 64'h0, 0);

        for (int i = 0; i < 25; i++) begin
            run_req(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) == 0) ? 64'h0 : {$urandom, $urandom},
                    int'($urandom_range(0, 3)));
        end

        // Seed load outside IDLE must not disturb the sequence.
        sat_mode = 0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seed_load = 1'b1;
        seed = 64'h1234_5678_9ABC_DEF0;
        repeat (3) @(posedge clk);
        #1;
        seed_load = 1'b0;
        repeat (10) begin
            if (!out_valid) begin
                @(posedge clk); #1;
            end
        end
        check_val("busy_seed_fail", 64'(out_fail), 64'd1);
        s = m_lfsr;
        repeat (MAX_TRIES) s = m_step(s);
        m_lfsr = s;
        exp_rej += int'(MAX_TRIES);
        check_val("busy_seed_var_1", 64'(out_var_1), 64'(13'(s >> 13)));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_req(1, 1'b0, 64'h0, 0);

`ifdef SAMPLER_STATS_EN
        check_val("stat_accept", 64'(stat_accept), 64'(exp_acc));
        check_val("stat_reject", 64'(stat_reject), 64'(exp_rej));
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
